// File: rtl/alu_ram_arbiter.sv
// alu_ram_arbiter: round-robin arbiter serialising NUM_REQ ALU requesters onto one RAM port.
// Supports load, store and atomic load-increment with per-requester page bounds checking.
module alu_ram_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [2*NUM_REQ-1:0]          req_op,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
    input  logic [16*NUM_REQ-1:0]         req_page,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic                          ram_we,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
    localparam logic [1:0] OpStore = 2'b01;
    localparam logic [1:0] OpLoadd = 2'b10;

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;
    state_e state_q, state_d;

    logic [GW-1:0]         last_grant_q, grant_q, sel, cand;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] offset_q, phys_q, ram_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, data_q, ram_wdata_q, rsp_data_q;
    logic [7:0]            len_q;

    logic                  any_req, accept, ovf;
    logic [1:0]            sel_op;
    logic [ADDR_WIDTH-1:0] sel_off, sel_phys;
    logic [DATA_WIDTH-1:0] sel_wdata, wr_data, rsp_val;
    logic [15:0]           sel_page;
    logic [SW-1:0]         sel_sum;
    logic                  sel_ovf;

    // First valid requester at or after last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = GW'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_off   = '0;
        sel_wdata = '0;
        sel_page  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_op    = req_op[i*2 +: 2];
                sel_off   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_page  = req_page[i*16 +: 16];
            end
        end
        sel_sum  = SW'(sel_page[7:0]) + SW'(sel_off);
        sel_phys = sel_sum[ADDR_WIDTH-1:0];
        sel_ovf  = SW'(sel_off) > SW'(sel_page[15:8]);
    end

    assign accept = (state_q == StIdle) && any_req && !rst;
    assign ovf    = SW'(offset_q) > SW'(len_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (sel_ovf)                 state_d = StResp;
                    else if (sel_op == OpStore)  state_d = StWr;
                    else                         state_d = StRd;
                end
            end
            StRd:    state_d = StRdw;
            StRdw:   state_d = (op_q == OpLoadd) ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_data = (op_q == OpStore) ? wdata_q : data_q + DATA_WIDTH'(1);
        rsp_val = ovf ? '0 : ((op_q == OpStore) ? wdata_q : data_q);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (sel == GW'(i));
            rsp_valid[i] = (state_q == StResp) && !rst && (grant_q == GW'(i));
        end
        rsp_err   = (state_q == StResp) && ovf && !rst;
        ram_we    = (state_q == StWr) && !rst;
        ram_addr  = (state_q == StRd || state_q == StWr) ? phys_q : ram_addr_q;
        ram_wdata = (state_q == StWr) ? wr_data : ram_wdata_q;
        rsp_data  = (state_q == StResp) ? rsp_val : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            op_q         <= '0;
            offset_q     <= '0;
            phys_q       <= '0;
            wdata_q      <= '0;
            len_q        <= '0;
            data_q       <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= sel;
                grant_q      <= sel;
                op_q         <= sel_op;
                offset_q     <= sel_off;
                phys_q       <= sel_phys;
                wdata_q      <= sel_wdata;
                len_q        <= sel_page[15:8];
            end
            if (state_q == StRdw) data_q <= ram_rdata;
            if (state_q == StRd || state_q == StWr) ram_addr_q <= phys_q;
            if (state_q == StWr) ram_wdata_q <= wr_data;
            if (state_q == StResp) rsp_data_q <= rsp_val;
        end
    end

endmodule

// File: tb/tb_alu_ram_arbiter.sv
// Self-checking bench for alu_ram_arbiter: RAM model, response scoreboard, one task per scenario.
module tb_alu_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req_valid = '0;
    logic [3:0]     req_ready;
    logic [7:0]     req_op = '0;
    logic [19:0]    req_addr = '0;
    logic [127:0]   req_wdata = '0;
    logic [63:0]    req_page = '0;
    logic [3:0]     rsp_valid;
    logic [31:0]    rsp_data;
    logic           rsp_err;
    logic [4:0]     ram_addr;
    logic           ram_we;
    logic [31:0]    ram_wdata;
    logic [31:0]    ram_rdata = '0;

    alu_ram_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_page(req_page), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;
    int cyc = 0, wr_count = 0, wr_cyc = 0, rsp_count = 0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] mem [32];

    // RAM model with one-cycle read latency plus write/response monitors.
    always @(posedge clk) begin
        if (ram_we) begin
            wr_count <= wr_count + 1;
            wr_addr  <= ram_addr;
            wr_data  <= ram_wdata;
            wr_cyc   <= cyc;
        end
        if (|rsp_valid) rsp_count <= rsp_count + 1;
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        cyc <= cyc + 1;
    end

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic [1:0] op, input logic [4:0] off,
                             input logic [31:0] wd, input logic [7:0] base,
                             input logic [7:0] len);
        req_op[r*2 +: 2]      = op;
        req_addr[r*AW +: AW]  = off;
        req_wdata[r*DW +: DW] = wd;
        req_page[r*16 +: 16]  = {len, base};
        req_valid[r]          = 1'b1;
    endtask

    task automatic await_ready(output bit ok, output logic [3:0] rdy, output int c);
        ok = 1'b0; rdy = '0; c = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (req_ready !== 4'b0000) begin
                ok = 1'b1; rdy = req_ready; c = cyc;
                return;
            end
        end
    endtask

    task automatic await_rsp(output bit ok, output logic [3:0] v, output logic [31:0] d,
                             output logic e, output int c);
        ok = 1'b0; v = '0; d = '0; e = 1'b0; c = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (rsp_valid !== 4'b0000) begin
                ok = 1'b1; v = rsp_valid; d = rsp_data; e = rsp_err; c = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_err !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b err=%b we=%b, want all 0",
                     req_ready, rsp_valid, rsp_err, ram_we);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; #1;
        checks++;
        if (ram_addr !== 5'd0 || ram_wdata !== 32'd0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: addr=%0d wdata=%h rsp_data=%h, want 0 0 0",
                     ram_addr, ram_wdata, rsp_data);
        end
    endtask

    task automatic test_load();
        bit ok; logic [3:0] v; logic [31:0] d; logic e; int c0, c; exp_t x;
        poke(5'd7, 32'h55);
        drive_req(0, 2'b00, 5'd2, 32'h0, 8'd5, 8'd10);
        await_ready(ok, v, c0);
        checks++;
        if (!ok || v !== 4'b0001) begin
            errors++; $display("FAIL load_ready: got %b, want 0001", v);
        end
        x.vld = 4'b0001; x.data = 32'h55; x.err = 1'b0; x.cyc = c0 + 3;
        sb.push_back(x);
        @(negedge clk); req_valid = '0; #1;
        checks++;
        if (ram_addr !== 5'd7 || ram_we !== 1'b0) begin
            errors++; $display("FAIL load_ram_addr: addr=%0d we=%b, want 7 0", ram_addr, ram_we);
        end
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL load_rsp: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_data !== 32'h55 || rsp_valid !== 4'b0) begin
            errors++;
            $display("FAIL load_hold: rsp_data=%h vld=%b, want 00000055 0000", rsp_data, rsp_valid);
        end
    endtask

    task automatic test_loadd();
        bit ok; logic [3:0] v; logic [31:0] d; logic e; int c0, c, wc; exp_t x;
        poke(5'd3, 32'hFFFF_FFFF);
        wc = wr_count;
        drive_req(1, 2'b10, 5'd3, 32'h0, 8'd0, 8'd31);
        await_ready(ok, v, c0);
        checks++;
        if (!ok || v !== 4'b0010) begin
            errors++; $display("FAIL loadd_ready: got %b, want 0010", v);
        end
        x.vld = 4'b0010; x.data = 32'hFFFF_FFFF; x.err = 1'b0; x.cyc = c0 + 4;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL loadd_rsp: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
        checks++;
        if (wr_count != wc + 1 || wr_addr !== 5'd3 || wr_data !== 32'd0 || wr_cyc != c0 + 3) begin
            errors++;
            $display("FAIL loadd_write: n=%0d addr=%0d data=%h cyc=%0d, want 1 3 0 %0d",
                     wr_count - wc, wr_addr, wr_data, wr_cyc, c0 + 3);
        end
    endtask

    task automatic test_overflow();
        bit ok; logic [3:0] v; logic [31:0] d; logic e; int c0, c, wc; exp_t x;
        wc = wr_count;
        @(negedge clk);
        drive_req(2, 2'b01, 5'd6, 32'hDEAD_BEEF, 8'd0, 8'd5);
        await_ready(ok, v, c0);
        x.vld = 4'b0100; x.data = 32'd0; x.err = 1'b1; x.cyc = c0 + 1;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL ovf_rsp: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_count != wc) begin
            errors++; $display("FAIL ovf_no_write: writes=%0d, want 0", wr_count - wc);
        end
        drive_req(2, 2'b01, 5'd5, 32'h1234_5678, 8'd0, 8'd5);
        await_ready(ok, v, c0);
        x.vld = 4'b0100; x.data = 32'h1234_5678; x.err = 1'b0; x.cyc = c0 + 2;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL edge_rsp: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
        checks++;
        if (wr_count != wc + 1 || wr_addr !== 5'd5 || wr_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL edge_write: n=%0d addr=%0d data=%h, want 1 5 12345678",
                     wr_count - wc, wr_addr, wr_data);
        end
    endtask

    task automatic test_wrap();
        bit ok; logic [3:0] v; logic [31:0] d; logic e; int c0, c; exp_t x;
        @(negedge clk);
        drive_req(3, 2'b01, 5'd4, 32'hA5A5_A5A5, 8'd30, 8'd4);
        await_ready(ok, v, c0);
        x.vld = 4'b1000; x.data = 32'hA5A5_A5A5; x.err = 1'b0; x.cyc = c0 + 2;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc ||
            wr_addr !== 5'd2) begin
            errors++;
            $display("FAIL wrap_store: vld=%b data=%h err=%b cyc=%0d waddr=%0d, want %b %h %b %0d 2",
                     v, d, e, c, wr_addr, x.vld, x.data, x.err, x.cyc);
        end
        @(negedge clk);
        drive_req(3, 2'b11, 5'd4, 32'h0, 8'd30, 8'd9);
        await_ready(ok, v, c0);
        x.vld = 4'b1000; x.data = 32'hA5A5_A5A5; x.err = 1'b0; x.cyc = c0 + 3;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL wrap_load: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int n_rdy = 0, n_rsp = 0, last_rsp = -10;
        logic [3:0] want;
        exp_t x;
        for (int r = 0; r < 4; r++) poke(5'(8 + r), 32'(100 + r));
        do_reset();
        for (int r = 0; r < 4; r++) drive_req(r, 2'b00, 5'(r), 32'h0, 8'd8, 8'd31);
        for (int i = 0; i < 80 && n_rsp < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (req_ready !== 4'b0000) begin
                want = (n_rdy < 5) ? 4'(1 << order[n_rdy]) : 4'b0000;
                checks++;
                if (req_ready !== want || (n_rdy > 0 && cyc != last_rsp + 1)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: ready=%b cyc=%0d, want %b cyc=%0d",
                             n_rdy, req_ready, cyc, want, last_rsp + 1);
                end
                x.vld = want; x.data = 32'(100 + order[n_rdy % 5]); x.err = 1'b0;
                x.cyc = cyc + 3;
                sb.push_back(x);
                n_rdy++;
            end
            if (rsp_valid !== 4'b0000) begin
                x = sb.pop_front();
                checks++;
                if (rsp_valid !== x.vld || rsp_data !== x.data || rsp_err !== x.err ||
                    cyc != x.cyc) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                             n_rsp, rsp_valid, rsp_data, rsp_err, cyc, x.vld, x.data, x.err,
                             x.cyc);
                end
                last_rsp = cyc;
                n_rsp++;
            end
        end
        checks++;
        if (n_rsp != 5) begin
            errors++; $display("FAIL rr_count: responses=%0d, want 5", n_rsp);
        end
        @(negedge clk); req_valid = '0;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        bit ok; logic [3:0] v; logic [31:0] d; logic e; int c0, c, rc, wc; exp_t x;
        @(negedge clk);
        drive_req(2, 2'b00, 5'd1, 32'h0, 8'd8, 8'd31);
        await_ready(ok, v, c0);
        @(negedge clk);
        req_valid = '0; rst = 1'b1; rc = rsp_count; wc = wr_count; #1;
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_err !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: ready=%b rsp_valid=%b err=%b we=%b, want all 0",
                     req_ready, rsp_valid, rsp_err, ram_we);
        end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_count != rc || wr_count != wc) begin
            errors++;
            $display("FAIL midrst_abort: rsp pulses=%0d writes=%0d, want 0 0",
                     rsp_count - rc, wr_count - wc);
        end
        drive_req(3, 2'b00, 5'd3, 32'h0, 8'd8, 8'd31);
        drive_req(0, 2'b00, 5'd0, 32'h0, 8'd8, 8'd31);
        #1;
        c0 = cyc;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_grant: ready=%b, want 0001", req_ready);
        end
        x.vld = 4'b0001; x.data = 32'd100; x.err = 1'b0; x.cyc = c0 + 3;
        sb.push_back(x);
        @(negedge clk); req_valid = '0;
        await_rsp(ok, v, d, e, c);
        x = sb.pop_front();
        checks++;
        if (!ok || v !== x.vld || d !== x.data || e !== x.err || c != x.cyc) begin
            errors++;
            $display("FAIL midrst_rsp: vld=%b data=%h err=%b cyc=%0d, want %b %h %b %0d",
                     v, d, e, c, x.vld, x.data, x.err, x.cyc);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_loadd();
        test_overflow();
        test_wrap();
        test_round_robin();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ram_arbiter.md
ALU_RAM_ARBITER -- requirements
Module: alu_ram_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_REQ, 4, number of ALU requesters.
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 5, RAM address width (32 entries).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester access request.
- req_ready, out, NUM_REQ, one-hot accept pulse.
- req_op, in, 2*NUM_REQ, per-requester op: 00 load, 01 store, 10 loadd (increment), 11 reserved, treated as load.
- req_addr, in, ADDR_WIDTH*NUM_REQ, per-requester tenant-relative offset.
- req_wdata, in, DATA_WIDTH*NUM_REQ, per-requester store data.
- req_page, in, 16*NUM_REQ, per-requester page entry {addr_len[15:8], base_addr[7:0]}.
- rsp_valid, out, NUM_REQ, one-hot response pulse.
- rsp_data, out, DATA_WIDTH, shared response data.
- rsp_err, out, 1, overflow flag, qualified by rsp_valid.
- ram_addr, out, ADDR_WIDTH, physical RAM address.
- ram_we, out, 1, RAM write enable.
- ram_wdata, out, DATA_WIDTH, RAM write data.
- ram_rdata, in, DATA_WIDTH, RAM read data, valid 1 cycle after ram_addr is presented with ram_we=0.
REQ-003 Requester i SHALL own slice i of every packed vector, at bits [(i+1)*W-1 : i*W].
REQ-004 The clock and reset SHALL be one clock, clk, and a synchronous active-high reset, rst.

Function
REQ-005 The block SHALL serialise all requesters onto the single RAM port, one transaction at a time.
REQ-006 The FSM states SHALL be IDLE, RD, RDW, WR and RESP.
REQ-007 Arbitration SHALL be round-robin, starting from last_grant+1 modulo NUM_REQ, and last_grant SHALL update on every accept.
REQ-008 In IDLE with any req_valid high, req_ready[g] SHALL pulse for exactly one cycle.
REQ-009 In that accept cycle, the block SHALL latch g, op, offset, wdata, addr_len and phys = (base_addr + offset) mod 2^ADDR_WIDTH.
REQ-010 On the same accept cycle, ovf SHALL be set to (offset > addr_len); offset == addr_len SHALL be legal.
REQ-011 From IDLE, the next state after accept SHALL be:
- RESP if ovf=1.
- WR if op is store.
- RD otherwise.
REQ-012 req_ready SHALL never assert outside IDLE, and requesters SHALL hold all request fields stable until their ready pulse.
REQ-013 RD SHALL drive ram_addr=phys with ram_we=0, then go to RDW.
REQ-014 RDW SHALL latch ram_rdata into the data register, then go to RESP for load or to WR for loadd.
REQ-015 WR SHALL drive ram_we=1 and ram_addr=phys for exactly one cycle, then go to RESP.
REQ-016 In WR, ram_wdata SHALL be the latched wdata for store, or the latched data + 1 modulo 2^DATA_WIDTH for loadd.
REQ-017 RESP SHALL pulse rsp_valid[g] for one cycle and then go to IDLE.
REQ-018 In RESP, rsp_data SHALL be:
- the loaded value for load;
- the pre-increment value for loadd;
- the store data for store;
- 0 on overflow.
REQ-019 rsp_err SHALL equal ovf in RESP and be 0 otherwise.
REQ-020 An overflowing request SHALL cause no RAM write.
REQ-021 Latency from accept cycle (cycle 0) to the rsp_valid cycle SHALL be:
- overflow: 1;
- store: 2;
- load: 3;
- loadd: 4.
REQ-022 Since IDLE re-arbitrates only after RESP, no two transactions SHALL overlap, and each loadd SHALL be atomic with respect to other requesters.
REQ-023 Outside WR, ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last values; rsp_data SHALL hold its last value between responses.

Reset
REQ-024 Reset SHALL set state to IDLE, last_grant to NUM_REQ-1 (so requester 0 has first priority), and set all latches, ram_addr, ram_wdata and rsp_data to 0.
REQ-025 During reset, req_ready, rsp_valid, rsp_err and ram_we SHALL all be 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no further RAM write and no rsp_valid pulse.

Verification
REQ-027 Load test: RAM[7]=0x55, req0 load, offset 2, page {10, 5} -> ram_addr=7, and rsp_valid[0] at cycle 3 with rsp_data=0x55 and rsp_err=0.
REQ-028 Loadd test: RAM[3]=0xFFFFFFFF, req1 loadd, offset 3, base 0, len 31 -> rsp_data=0xFFFFFFFF at cycle 4, with exactly one ram_we at cycle 3 writing 0.
REQ-029 Overflow test: req2 store, offset 6, len 5 -> rsp_err=1 and rsp_data=0 at cycle 1, with ram_we never asserted; offset 5 with len 5 -> write performed.
REQ-030 Round-robin test: all four req_valid held high after reset -> grant order 0, 1, 2, 3, 0, with each ready pulse exactly one cycle after the previous RESP.
REQ-031 Wrap test: base 30 with offset 4 -> ram_addr=2, with no error when len is 4 or more.
REQ-032 Reset test: rst asserted in RD of a load -> no rsp_valid pulse, state IDLE, and the next accept goes to requester 0.
